alu_arbiter: RTL and testbench

- Shares the single RV32I ALU between two requesters: req0, the integer-execute path, and req1, the address/branch-compare path.
- Uses a valid/ready request handshake, round-robin grant, and a registered operand stage in front of the ALU.
- Returns a registered result and zero flag to the granted requester through a valid/ready response handshake.
- Sits between the requester logic and the combinational ALU; the ALU itself is instantiated outside this block.

---
 rtl/alu_arbiter.sv | 165 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational RV32I ALU between two requesters:
//     req0 - integer-execute path
//     req1 - address / branch-compare path
//   Flow per operation: IDLE (accept) -> EXEC (ALU evaluates the registered
//   operands) -> RESP (registered result held until the owner consumes it).
//   Minimum three cycles per operation; no new request is taken while busy.
//
//   Optional build macro: ALU_ARB_FIXED_PRIO_EN
//     undefined (default): round-robin, requester not served last wins ties
//     defined            : req0 always wins ties, req1 served only when req0
//                          is idle
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPC_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  // requester 0
  input  logic             i_req0_vld,
  output logic             o_req0_rdy,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic [OPC_W-1:0] i_req0_opc,
  // requester 1
  input  logic             i_req1_vld,
  output logic             o_req1_rdy,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  input  logic [OPC_W-1:0] i_req1_opc,
  // responses
  output logic             o_rsp0_vld,
  input  logic             i_rsp0_rdy,
  output logic             o_rsp1_vld,
  input  logic             i_rsp1_rdy,
  output logic [WIDTH-1:0] o_rsp_rslt,
  output logic             o_rsp_zr,
  // external ALU
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [OPC_W-1:0] o_alu_opc,
  input  logic [WIDTH-1:0] i_alu_rslt,
  input  logic             i_alu_zr,
  // status
  output logic             o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last;      // requester that completed most recently
  logic             r_gnt;       // requester owning the in-flight operation
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [OPC_W-1:0] r_op_opc;
  logic [WIDTH-1:0] r_rsp_rslt;
  logic             r_rsp_zr;
  logic             r_rsp0_vld;
  logic             r_rsp1_vld;
  logic             r_busy;

  logic             w_pick1;     // 1: req1 would be granted, 0: req0
  logic             w_idle;
  logic             w_accept;
  logic             w_rsp_done;

  // Arbitration decision among the currently valid requesters.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    w_pick1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    w_pick1 = i_req1_vld && !i_req0_vld;
`else
    if (i_req0_vld && i_req1_vld) begin
      w_pick1 = !r_last;
    end else begin
      w_pick1 = i_req1_vld;
    end
`endif
  end

  // NOTE: the ready strobes are combinational, so they are qualified with the
  // reset input to make them drop the instant reset asserts, like the
  // registered outputs do.
  assign w_idle     = (r_state == ST_IDLE) && i_rst_n;
  assign o_req0_rdy = w_idle && i_req0_vld && !w_pick1;
  assign o_req1_rdy = w_idle && i_req1_vld &&  w_pick1;
  assign w_accept   = o_req0_rdy || o_req1_rdy;

  // Only the owner's ready completes a response; the other one is ignored.
  assign w_rsp_done = (r_rsp0_vld && i_rsp0_rdy) || (r_rsp1_vld && i_rsp1_rdy);

  // Operation sequencer: accept, execute for one cycle, hold the response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: operand and result registers are reset too, because the ALU and
    // response buses are visible outputs that must read zero during reset.
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_last     <= 1'b1;
      r_gnt      <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_opc   <= '0;
      r_rsp_rslt <= '0;
      r_rsp_zr   <= 1'b0;
      r_rsp0_vld <= 1'b0;
      r_rsp1_vld <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples values from before this edge.
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_gnt    <= w_pick1;
            r_op_a   <= w_pick1 ? i_req1_a   : i_req0_a;
            r_op_b   <= w_pick1 ? i_req1_b   : i_req0_b;
            r_op_opc <= w_pick1 ? i_req1_opc : i_req0_opc;
            r_busy   <= 1'b1;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_rslt <= i_alu_rslt;
          r_rsp_zr   <= i_alu_zr;
          r_rsp0_vld <= !r_gnt;
          r_rsp1_vld <=  r_gnt;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_done) begin
            r_rsp0_vld <= 1'b0;
            r_rsp1_vld <= 1'b0;
            r_last     <= r_gnt;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The ALU sees the operand registers directly, so its inputs hold the last
  // operands outside EXEC instead of returning to zero.
  assign o_alu_a    = r_op_a;
  assign o_alu_b    = r_op_b;
  assign o_alu_opc  = r_op_opc;

  assign o_rsp_rslt = r_rsp_rslt;
  assign o_rsp_zr   = r_rsp_zr;
  assign o_rsp0_vld = r_rsp0_vld;
  assign o_rsp1_vld = r_rsp1_vld;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed sequence followed by a randomized phase. The bench owns a
//   behavioural ALU (driving the DUT's ALU port) and a transaction-level model
//   of the arbitration order and timing.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  opc;
  } op_t;

  logic        clk;
  logic        rst_n;
  logic        req0_vld, req1_vld;
  logic        req0_rdy, req1_rdy;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_opc, req1_opc;
  logic        rsp0_vld, rsp1_vld;
  logic        rsp0_rdy, rsp1_rdy;
  logic [31:0] rsp_rslt;
  logic        rsp_zr;
  logic [31:0] alu_a, alu_b, alu_rslt;
  logic [2:0]  alu_opc;
  logic        alu_zr;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int m_last;           // model: requester that completed last

  alu_arbiter #(.WIDTH(32), .OPC_W(3)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req0_vld (req0_vld),
    .o_req0_rdy (req0_rdy),
    .i_req0_a   (req0_a),
    .i_req0_b   (req0_b),
    .i_req0_opc (req0_opc),
    .i_req1_vld (req1_vld),
    .o_req1_rdy (req1_rdy),
    .i_req1_a   (req1_a),
    .i_req1_b   (req1_b),
    .i_req1_opc (req1_opc),
    .o_rsp0_vld (rsp0_vld),
    .i_rsp0_rdy (rsp0_rdy),
    .o_rsp1_vld (rsp1_vld),
    .i_rsp1_rdy (rsp1_rdy),
    .o_rsp_rslt (rsp_rslt),
    .o_rsp_zr   (rsp_zr),
    .o_alu_a    (alu_a),
    .o_alu_b    (alu_b),
    .o_alu_opc  (alu_opc),
    .i_alu_rslt (alu_rslt),
    .i_alu_zr   (alu_zr),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32I ALU behaviour for the eight supported op-codes.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] opc);
    case (opc)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6:    return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  // External combinational ALU seen by the DUT.
  always_comb begin
    alu_rslt = alu_ref(alu_a, alu_b, alu_opc);
    alu_zr   = (alu_rslt == 32'd0);
  end

  // Model of which requester is granted when the given ones are valid.
  function automatic int pick(input bit v0, input bit v1);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return v0 ? 0 : 1;
`else
    if (v0 && v1) return (m_last == 1) ? 0 : 1;
    return v0 ? 0 : 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int s, input bit v, input op_t p);
    if (s == 0) begin
      req0_vld = v; req0_a = p.a; req0_b = p.b; req0_opc = p.opc;
    end else begin
      req1_vld = v; req1_a = p.a; req1_b = p.b; req1_opc = p.opc;
    end
  endtask

  function automatic op_t mk(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
    op_t p;
    p.a = a; p.b = b; p.opc = opc;
    return p;
  endfunction

  function automatic op_t rand_op();
    op_t p;
    p.a   = $urandom;
    p.b   = ($urandom_range(0, 3) == 0) ? p.a : $urandom;
    p.opc = 3'($urandom_range(0, 7));
    return p;
  endfunction

  task automatic check_all_zero(input string tag);
    check_b({tag, "_rdy0"}, req0_rdy, 1'b0);
    check_b({tag, "_rdy1"}, req1_rdy, 1'b0);
    check_b({tag, "_rsp0_vld"}, rsp0_vld, 1'b0);
    check_b({tag, "_rsp1_vld"}, rsp1_vld, 1'b0);
    check({tag, "_rslt"}, rsp_rslt, 32'd0);
    check_b({tag, "_zr"}, rsp_zr, 1'b0);
    check({tag, "_alu_a"}, alu_a, 32'd0);
    check({tag, "_alu_b"}, alu_b, 32'd0);
    check({tag, "_alu_opc"}, {29'd0, alu_opc}, 32'd0);
    check_b({tag, "_busy"}, busy, 1'b0);
  endtask

  // One complete operation for requester g. Called just after a rising edge
  // with the request inputs already driven; returns just after the edge on
  // which the arbiter is back in IDLE, three + hold cycles later.
  task automatic expect_txn(input int g, input op_t p, input int hold);
    logic [31:0] er;
    logic        ez;
    er = alu_ref(p.a, p.b, p.opc);
    ez = (er == 32'd0);
    #1;
    check_b("acc_rdy0", req0_rdy, g == 0);
    check_b("acc_rdy1", req1_rdy, g == 1);
    check_b("acc_busy", busy, 1'b0);
    check_b("acc_rsp0_vld", rsp0_vld, 1'b0);
    check_b("acc_rsp1_vld", rsp1_vld, 1'b0);
    tick();
    if (g == 0) req0_vld = 1'b0; else req1_vld = 1'b0;
    #1;
    check_b("exec_busy", busy, 1'b1);
    check_b("exec_rdy0", req0_rdy, 1'b0);
    check_b("exec_rdy1", req1_rdy, 1'b0);
    check("exec_alu_a", alu_a, p.a);
    check("exec_alu_b", alu_b, p.b);
    check("exec_alu_opc", {29'd0, alu_opc}, {29'd0, p.opc});
    check_b("exec_rsp0_vld", rsp0_vld, 1'b0);
    check_b("exec_rsp1_vld", rsp1_vld, 1'b0);
    for (int h = 0; h <= hold; h++) begin
      tick();
      if (g == 0) begin
        rsp0_rdy = (h == hold); rsp1_rdy = 1'($urandom_range(0, 1));
      end else begin
        rsp1_rdy = (h == hold); rsp0_rdy = 1'($urandom_range(0, 1));
      end
      #1;
      check_b("resp_vld0", rsp0_vld, g == 0);
      check_b("resp_vld1", rsp1_vld, g == 1);
      check("resp_rslt", rsp_rslt, er);
      check_b("resp_zr", rsp_zr, ez);
      check_b("resp_busy", busy, 1'b1);
      check_b("resp_rdy0", req0_rdy, 1'b0);
      check_b("resp_rdy1", req1_rdy, 1'b0);
      check("resp_alu_a_held", alu_a, p.a);
    end
    tick();
    rsp0_rdy = 1'b0;
    rsp1_rdy = 1'b0;
    m_last = g;
  endtask

  bit  pend [2];
  op_t pl   [2];

  initial begin
    int  g;
    op_t p0, p1;
    rst_n = 1'b0;
    req0_vld = 1'b0; req1_vld = 1'b0;
    req0_a = '0; req0_b = '0; req0_opc = '0;
    req1_a = '0; req1_b = '0; req1_opc = '0;
    rsp0_rdy = 1'b0; rsp1_rdy = 1'b0;
    m_last = 1;

    // Reset: outputs quiet even with requests pending.
    #1;
    req0_vld = 1'b1; req1_vld = 1'b1;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    req0_vld = 1'b0; req1_vld = 1'b0;
    rst_n = 1'b1;
    #1;
    check_all_zero("post_reset");
    tick();

    // 1: single ADD on req0.
    p0 = mk(3'd0, 32'h0000_000A, 32'h0000_0005);
    drive_req(0, 1'b1, p0);
    expect_txn(pick(1'b1, 1'b0), p0, 0);

    // 2: simultaneous requests, then continuous contention.
    p0 = mk(3'd1, 32'h0000_000A, 32'h0000_0005);
    p1 = mk(3'd4, 32'h0000_000F, 32'h0000_0003);
    drive_req(0, 1'b1, p0);
    drive_req(1, 1'b1, p1);
    g = pick(1'b1, 1'b1);
    expect_txn(g, (g == 0) ? p0 : p1, 0);
    if (g == 0) begin
      // req0 returns immediately; req1 still waiting
      p0 = mk(3'd2, 32'hFF00_FF00, 32'h0F0F_0F0F);
      drive_req(0, 1'b1, p0);
      g = pick(1'b1, 1'b1);
      expect_txn(g, (g == 0) ? p0 : p1, 0);
    end
    g = pick(req0_vld, req1_vld);
    expect_txn(g, (g == 0) ? p0 : p1, 0);

    // 3: req1 ADD 0,0 with a stalled consumer while req0 waits.
    p0 = mk(3'd3, 32'h1234_0000, 32'h0000_5678);
    p1 = mk(3'd0, 32'h0000_0000, 32'h0000_0000);
    drive_req(0, 1'b1, p0);
    drive_req(1, 1'b1, p1);
    g = pick(1'b1, 1'b1);
    expect_txn(g, (g == 0) ? p0 : p1, 5);
    g = pick(req0_vld, req1_vld);
    expect_txn(g, (g == 0) ? p0 : p1, 0);

    // 4: back-to-back shifts on req0, consumer always ready.
    p0 = mk(3'd6, 32'd1, 32'd2);
    drive_req(0, 1'b1, p0);
    expect_txn(0, p0, 0);
    p0 = mk(3'd7, 32'd4, 32'd2);
    drive_req(0, 1'b1, p0);
    expect_txn(0, p0, 0);

    // 5: reset during EXEC discards the operation.
    p0 = mk(3'd5, 32'd5, 32'd10);
    drive_req(0, 1'b1, p0);
    #1;
    check_b("rst5_acc_rdy0", req0_rdy, 1'b1);
    tick();
    req0_vld = 1'b0;
    #1;
    check_b("rst5_exec_busy", busy, 1'b1);
    rst_n = 1'b0;
    req1_vld = 1'b1;
    #1;
    check_all_zero("rst5_mid");
    tick();
    check_all_zero("rst5_hold");
    req1_vld = 1'b0;
    rst_n = 1'b1;
    m_last = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_b("rst5_no_rsp0", rsp0_vld, 1'b0);
      check_b("rst5_idle_busy", busy, 1'b0);
    end
    p1 = mk(3'd0, 32'h0000_0100, 32'h0000_0023);
    drive_req(1, 1'b1, p1);
    expect_txn(pick(1'b0, 1'b1), p1, 0);
    p0 = mk(3'd1, 32'd7, 32'd7);
    p1 = mk(3'd3, 32'h8000_0000, 32'd1);
    drive_req(0, 1'b1, p0);
    drive_req(1, 1'b1, p1);
    g = pick(1'b1, 1'b1);
    expect_txn(g, (g == 0) ? p0 : p1, 1);
    g = pick(req0_vld, req1_vld);
    expect_txn(g, (g == 0) ? p0 : p1, 0);

    // Randomized traffic against the model.
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int it = 0; it < 40; it++) begin
      for (int s = 0; s < 2; s++) begin
        if (!pend[s] && $urandom_range(0, 2) != 0) begin
          pend[s] = 1'b1;
          pl[s]   = rand_op();
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1'b1;
        pl[0]   = rand_op();
      end
      drive_req(0, pend[0], pl[0]);
      drive_req(1, pend[1], pl[1]);
      g = pick(pend[0], pend[1]);
      expect_txn(g, pl[g], $urandom_range(0, 3));
      pend[g] = 1'b0;
    end
    while (pend[0] || pend[1]) begin
      g = pick(pend[0], pend[1]);
      expect_txn(g, pl[g], 0);
      pend[g] = 1'b0;
    end
    #1;
    check_b("final_rsp0_vld", rsp0_vld, 1'b0);
    check_b("final_rsp1_vld", rsp1_vld, 1'b0);
    check_b("final_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
